// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Bundles the EXE/MEM -> MEM stage inputs and the MEM stage outputs towards
//   MEM/WB and the hazard logic.
//   master modport: the upstream pipeline side (drives *_in, observes outputs).
//   slave  modport: the MEM stage itself.
//   Signals:
//     wb_enable_in / mem_read_enable_in / mem_write_enable_in  control from EXE/MEM
//     dest_in, pc_in, alu_res_in, val_rm_in                    data from EXE/MEM
//     wb_enable_out, mem_read_enable_out, dest_out, pc_out,
//     alu_res_out                                              pass-through to MEM/WB
//     mem_result                                               load data
//     ready / freeze                                           stage advance / stall
interface mem_stage_if;
  logic        wb_enable_in;
  logic        mem_read_enable_in;
  logic        mem_write_enable_in;
  logic [3:0]  dest_in;
  logic [31:0] pc_in;
  logic [31:0] alu_res_in;
  logic [31:0] val_rm_in;

  logic        wb_enable_out;
  logic        mem_read_enable_out;
  logic [3:0]  dest_out;
  logic [31:0] pc_out;
  logic [31:0] alu_res_out;
  logic [31:0] mem_result;
  logic        ready;
  logic        freeze;

  modport master (
    output wb_enable_in, mem_read_enable_in, mem_write_enable_in,
           dest_in, pc_in, alu_res_in, val_rm_in,
    input  wb_enable_out, mem_read_enable_out, dest_out, pc_out,
           alu_res_out, mem_result, ready, freeze
  );

  modport slave (
    input  wb_enable_in, mem_read_enable_in, mem_write_enable_in,
           dest_in, pc_in, alu_res_in, val_rm_in,
    output wb_enable_out, mem_read_enable_out, dest_out, pc_out,
           alu_res_out, mem_result, ready, freeze
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
//   Memory stage of the 5-stage pipeline. Services loads and stores against an
//   internal word-addressed data memory with a fixed access latency, raising
//   freeze so the upstream stages hold while an access is outstanding, and
//   forwards control and the ALU result to the MEM/WB register.
//   Ports:
//     clk  in  clock, rising edge
//     rst  in  asynchronous reset, active-high
//     bus  slave side of mem_stage_if (EXE/MEM inputs, MEM/WB outputs,
//          mem_result, ready, freeze)
//   Parameters:
//     WAIT_CYCLES  access latency in cycles (1..15)
//     DEPTH        data memory depth in 32-bit words
//     ADDR_BASE    byte address mapped to word 0
module mem_stage #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 64,
  parameter int ADDR_BASE   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_result_q;
  logic [31:0] mem_q [DEPTH];

  logic        req;
  logic        ready_c;
  logic        load_capture;
  logic        store_commit;
  logic [31:0] byte_off;
  logic [31:0] word_off;
  logic [AW-1:0] idx;
  logic        in_range;

  // Pass-through to MEM/WB; these carry no state of their own.
  assign bus.wb_enable_out       = bus.wb_enable_in;
  assign bus.mem_read_enable_out = bus.mem_read_enable_in;
  assign bus.dest_out            = bus.dest_in;
  assign bus.pc_out              = bus.pc_in;
  assign bus.alu_res_out         = bus.alu_res_in;

  assign req = bus.mem_read_enable_in | bus.mem_write_enable_in;

  // Word index relative to ADDR_BASE. The byte offset wraps for addresses
  // below the base, so the explicit >= test is what rejects them.
  assign byte_off = bus.alu_res_in - 32'(ADDR_BASE);
  assign word_off = byte_off >> 2;
  assign idx      = word_off[AW-1:0];
  assign in_range = (bus.alu_res_in >= 32'(ADDR_BASE)) && (word_off < 32'(DEPTH));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_c      = 1'b1;
    load_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          ready_c = 1'b0;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          if (WAIT_CYCLES == 1) begin
            state_d      = DONE;
            load_capture = bus.mem_read_enable_in;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        ready_c = 1'b0;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d      = DONE;
          load_capture = bus.mem_read_enable_in;
        end
      end
      DONE: begin
        // Pipeline advances on the edge leaving DONE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load data is captured on the edge entering DONE, before any store of the
  // same instruction commits, so a read+write returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_result_q <= 32'd0;
    end else if (load_capture) begin
      mem_result_q <= in_range ? mem_q[idx] : 32'd0;
    end
  end

  // Store commits on the edge leaving DONE. Reset forces IDLE asynchronously,
  // so an interrupted store can never reach this point. The array itself is
  // never cleared.
  assign store_commit = (state_q == DONE) && bus.mem_write_enable_in && in_range;

  always_ff @(posedge clk) begin
    if (store_commit) begin
      mem_q[idx] <= bus.val_rm_in;
    end
  end

  assign bus.mem_result = mem_result_q;
  assign bus.ready      = ready_c;
  assign bus.freeze     = ~ready_c;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int W_A = 2;
  localparam int W_B = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus_a ();
  mem_stage_if bus_b ();

  mem_stage #(.WAIT_CYCLES(W_A), .DEPTH(64), .ADDR_BASE(1024)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_stage #(.WAIT_CYCLES(W_B), .DEPTH(64), .ADDR_BASE(1024)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    int          tag;
    bit          is_load;
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   tag_ctr  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_pop(input int d, input logic [31:0] res, input logic frz);
    exp_t e;
    int   lat;
    bit   empty;
    empty = (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    if (empty) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d unexpected completion: result 0x%08h with no pending op", d, res);
      return;
    end
    if (d == 0) e = q_a.pop_front();
    else        e = q_b.pop_front();
    lat = cyc - e.issue;
    check32($sformatf("dut%0d op%0d latency", d, e.tag), 32'(lat), 32'(e.lat));
    check32($sformatf("dut%0d op%0d freeze at ready", d, e.tag), {31'd0, frz}, 32'd0);
    if (e.is_load)
      check32($sformatf("dut%0d op%0d load data", d, e.tag), res, e.data);
    $display("dut%0d op%0d %s done: latency %0d result 0x%08h", d, e.tag,
             e.is_load ? "load " : "store", lat, res);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if ((bus_a.mem_read_enable_in | bus_a.mem_write_enable_in) && bus_a.ready === 1'b1)
        mon_pop(0, bus_a.mem_result, bus_a.freeze);
      if ((bus_b.mem_read_enable_in | bus_b.mem_write_enable_in) && bus_b.ready === 1'b1)
        mon_pop(1, bus_b.mem_result, bus_b.freeze);
    end
  end

  // ---------------- driver ----------------
  task automatic set_in(input int d, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data);
    if (d == 0) begin
      bus_a.mem_read_enable_in  = rd;
      bus_a.mem_write_enable_in = wr;
      bus_a.wb_enable_in        = rd;
      bus_a.alu_res_in          = addr;
      bus_a.val_rm_in           = data;
      bus_a.dest_in             = addr[5:2];
      bus_a.pc_in               = 32'h4000 + addr;
    end else begin
      bus_b.mem_read_enable_in  = rd;
      bus_b.mem_write_enable_in = wr;
      bus_b.wb_enable_in        = rd;
      bus_b.alu_res_in          = addr;
      bus_b.val_rm_in           = data;
      bus_b.dest_in             = addr[5:2];
      bus_b.pc_in               = 32'h4000 + addr;
    end
  endtask

  task automatic do_op(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_data);
    exp_t e;
    bit   done;
    @(posedge clk);
    #1;
    set_in(d, rd, wr, addr, data);
    e.tag     = tag_ctr;
    tag_ctr++;
    e.is_load = rd;
    e.data    = exp_data;
    e.issue   = cyc;
    e.lat     = (d == 0) ? W_A : W_B;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (((d == 0) ? bus_a.ready : bus_b.ready) === 1'b1) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d op%0d timeout: ready still 0 after 40 cycles, required 1", d, e.tag);
    end
  endtask

  task automatic go_idle(input int d);
    @(posedge clk);
    #1;
    set_in(d, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check32("reset mem_result a", bus_a.mem_result, 32'd0);
    check32("reset mem_result b", bus_b.mem_result, 32'd0);
    check32("reset ready", {31'd0, bus_a.ready}, 32'd1);
    check32("reset freeze", {31'd0, bus_a.freeze}, 32'd0);
    rst = 1'b0;

    // 1: preload word 0, then load it back
    do_op(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0);
    do_op(0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF);
    // 2: store/load at 1028
    do_op(0, 1'b0, 1'b1, 32'd1028, 32'h12345678, 32'd0);
    do_op(0, 1'b1, 1'b0, 32'd1028, 32'd0, 32'h12345678);
    go_idle(0);

    // 3: idle cycles, pass-through follows inputs in the same cycle
    for (int i = 0; i < 10; i++) begin
      logic [31:0] v;
      v = 32'h1000 + 32'(i) * 32'd4;
      @(posedge clk);
      #1;
      bus_a.alu_res_in   = v;
      bus_a.dest_in      = 4'(i);
      bus_a.wb_enable_in = i[0];
      #1;
      check32($sformatf("idle%0d alu_res_out", i), bus_a.alu_res_out, v);
      check32($sformatf("idle%0d dest_out", i), {28'd0, bus_a.dest_out}, 32'(i));
      check32($sformatf("idle%0d wb_enable_out", i), {31'd0, bus_a.wb_enable_out}, 32'(i % 2));
      check32($sformatf("idle%0d ready", i), {31'd0, bus_a.ready}, 32'd1);
      check32($sformatf("idle%0d freeze", i), {31'd0, bus_a.freeze}, 32'd0);
    end

    // 4: out-of-range stores dropped, loads return 0, top word works
    do_op(0, 1'b0, 1'b1, 32'd1020, 32'h11111111, 32'd0);
    do_op(0, 1'b0, 1'b1, 32'd1280, 32'h22222222, 32'd0);
    do_op(0, 1'b1, 1'b0, 32'd1020, 32'd0, 32'd0);
    do_op(0, 1'b1, 1'b0, 32'd1280, 32'd0, 32'd0);
    do_op(0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF);
    do_op(0, 1'b1, 1'b0, 32'd1028, 32'd0, 32'h12345678);
    do_op(0, 1'b0, 1'b1, 32'd1276, 32'h0BADCAFE, 32'd0);
    do_op(0, 1'b1, 1'b0, 32'd1276, 32'd0, 32'h0BADCAFE);
    // read+write together: old data returned, store commits
    do_op(0, 1'b1, 1'b1, 32'd1028, 32'h55555555, 32'h12345678);
    do_op(0, 1'b1, 1'b0, 32'd1028, 32'd0, 32'h55555555);
    go_idle(0);

    // 5: reset in BUSY of a store
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 32'd1024, 32'd0);
    #1;
    check32("midreset mem_result", bus_a.mem_result, 32'd0);
    check32("midreset ready", {31'd0, bus_a.ready}, 32'd1);
    check32("midreset freeze", {31'd0, bus_a.freeze}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op(0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF);
    go_idle(0);

    // 6: single-cycle build, back-to-back traffic
    do_op(1, 1'b0, 1'b1, 32'd1024, 32'hA0000001, 32'd0);
    do_op(1, 1'b0, 1'b1, 32'd1032, 32'hB0000002, 32'd0);
    do_op(1, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hA0000001);
    do_op(1, 1'b1, 1'b0, 32'd1032, 32'd0, 32'hB0000002);
    do_op(1, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hA0000001);
    do_op(1, 1'b1, 1'b0, 32'd4, 32'd0, 32'd0);
    go_idle(1);

    repeat (3) @(posedge clk);
    #1;
    check32("dut_a pending ops", 32'(q_a.size()), 32'd0);
    check32("dut_b pending ops", 32'(q_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
